sub_bytes_engine: RTL and testbench

//  Forward AES SubBytes on a 128-bit state. Complements the combinational inverse S-box used on the decrypt path.

---
 rtl/aes_pkg.sv | 14 +
 rtl/sub_bytes_engine_sbox.sv | 30 +++
 rtl/sub_bytes_engine.sv | 94 +++++++++
 tb/tb_sub_bytes_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the SubBytes engine state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_RUN  = 2'd1,
        SB_DONE = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sub_bytes_engine_sbox.sv
// FIPS-197 forward S-box as a purely combinational lookup; bit 0 of sbin/sbout is the byte MSB.
module sbox (
    input  logic [0:7] sbin,
    output logic [0:7] sbout
);

    always_comb begin
        sbout = 8'h00;
        case (sbin)
            8'h00: sbout = 8'h63; 8'h01: sbout = 8'h7c; 8'h02: sbout = 8'h77; 8'h03: sbout = 8'h7b; 8'h04: sbout = 8'hf2; 8'h05: sbout = 8'h6b; 8'h06: sbout = 8'h6f; 8'h07: sbout = 8'hc5; 8'h08: sbout = 8'h30; 8'h09: sbout = 8'h01; 8'h0a: sbout = 8'h67; 8'h0b: sbout = 8'h2b; 8'h0c: sbout = 8'hfe; 8'h0d: sbout = 8'hd7; 8'h0e: sbout = 8'hab; 8'h0f: sbout = 8'h76;
            8'h10: sbout = 8'hca; 8'h11: sbout = 8'h82; 8'h12: sbout = 8'hc9; 8'h13: sbout = 8'h7d; 8'h14: sbout = 8'hfa; 8'h15: sbout = 8'h59; 8'h16: sbout = 8'h47; 8'h17: sbout = 8'hf0; 8'h18: sbout = 8'had; 8'h19: sbout = 8'hd4; 8'h1a: sbout = 8'ha2; 8'h1b: sbout = 8'haf; 8'h1c: sbout = 8'h9c; 8'h1d: sbout = 8'ha4; 8'h1e: sbout = 8'h72; 8'h1f: sbout = 8'hc0;
            8'h20: sbout = 8'hb7; 8'h21: sbout = 8'hfd; 8'h22: sbout = 8'h93; 8'h23: sbout = 8'h26; 8'h24: sbout = 8'h36; 8'h25: sbout = 8'h3f; 8'h26: sbout = 8'hf7; 8'h27: sbout = 8'hcc; 8'h28: sbout = 8'h34; 8'h29: sbout = 8'ha5; 8'h2a: sbout = 8'he5; 8'h2b: sbout = 8'hf1; 8'h2c: sbout = 8'h71; 8'h2d: sbout = 8'hd8; 8'h2e: sbout = 8'h31; 8'h2f: sbout = 8'h15;
            8'h30: sbout = 8'h04; 8'h31: sbout = 8'hc7; 8'h32: sbout = 8'h23; 8'h33: sbout = 8'hc3; 8'h34: sbout = 8'h18; 8'h35: sbout = 8'h96; 8'h36: sbout = 8'h05; 8'h37: sbout = 8'h9a; 8'h38: sbout = 8'h07; 8'h39: sbout = 8'h12; 8'h3a: sbout = 8'h80; 8'h3b: sbout = 8'he2; 8'h3c: sbout = 8'heb; 8'h3d: sbout = 8'h27; 8'h3e: sbout = 8'hb2; 8'h3f: sbout = 8'h75;
            8'h40: sbout = 8'h09; 8'h41: sbout = 8'h83; 8'h42: sbout = 8'h2c; 8'h43: sbout = 8'h1a; 8'h44: sbout = 8'h1b; 8'h45: sbout = 8'h6e; 8'h46: sbout = 8'h5a; 8'h47: sbout = 8'ha0; 8'h48: sbout = 8'h52; 8'h49: sbout = 8'h3b; 8'h4a: sbout = 8'hd6; 8'h4b: sbout = 8'hb3; 8'h4c: sbout = 8'h29; 8'h4d: sbout = 8'he3; 8'h4e: sbout = 8'h2f; 8'h4f: sbout = 8'h84;
            8'h50: sbout = 8'h53; 8'h51: sbout = 8'hd1; 8'h52: sbout = 8'h00; 8'h53: sbout = 8'hed; 8'h54: sbout = 8'h20; 8'h55: sbout = 8'hfc; 8'h56: sbout = 8'hb1; 8'h57: sbout = 8'h5b; 8'h58: sbout = 8'h6a; 8'h59: sbout = 8'hcb; 8'h5a: sbout = 8'hbe; 8'h5b: sbout = 8'h39; 8'h5c: sbout = 8'h4a; 8'h5d: sbout = 8'h4c; 8'h5e: sbout = 8'h58; 8'h5f: sbout = 8'hcf;
            8'h60: sbout = 8'hd0; 8'h61: sbout = 8'hef; 8'h62: sbout = 8'haa; 8'h63: sbout = 8'hfb; 8'h64: sbout = 8'h43; 8'h65: sbout = 8'h4d; 8'h66: sbout = 8'h33; 8'h67: sbout = 8'h85; 8'h68: sbout = 8'h45; 8'h69: sbout = 8'hf9; 8'h6a: sbout = 8'h02; 8'h6b: sbout = 8'h7f; 8'h6c: sbout = 8'h50; 8'h6d: sbout = 8'h3c; 8'h6e: sbout = 8'h9f; 8'h6f: sbout = 8'ha8;
            8'h70: sbout = 8'h51; 8'h71: sbout = 8'ha3; 8'h72: sbout = 8'h40; 8'h73: sbout = 8'h8f; 8'h74: sbout = 8'h92; 8'h75: sbout = 8'h9d; 8'h76: sbout = 8'h38; 8'h77: sbout = 8'hf5; 8'h78: sbout = 8'hbc; 8'h79: sbout = 8'hb6; 8'h7a: sbout = 8'hda; 8'h7b: sbout = 8'h21; 8'h7c: sbout = 8'h10; 8'h7d: sbout = 8'hff; 8'h7e: sbout = 8'hf3; 8'h7f: sbout = 8'hd2;
            8'h80: sbout = 8'hcd; 8'h81: sbout = 8'h0c; 8'h82: sbout = 8'h13; 8'h83: sbout = 8'hec; 8'h84: sbout = 8'h5f; 8'h85: sbout = 8'h97; 8'h86: sbout = 8'h44; 8'h87: sbout = 8'h17; 8'h88: sbout = 8'hc4; 8'h89: sbout = 8'ha7; 8'h8a: sbout = 8'h7e; 8'h8b: sbout = 8'h3d; 8'h8c: sbout = 8'h64; 8'h8d: sbout = 8'h5d; 8'h8e: sbout = 8'h19; 8'h8f: sbout = 8'h73;
            8'h90: sbout = 8'h60; 8'h91: sbout = 8'h81; 8'h92: sbout = 8'h4f; 8'h93: sbout = 8'hdc; 8'h94: sbout = 8'h22; 8'h95: sbout = 8'h2a; 8'h96: sbout = 8'h90; 8'h97: sbout = 8'h88; 8'h98: sbout = 8'h46; 8'h99: sbout = 8'hee; 8'h9a: sbout = 8'hb8; 8'h9b: sbout = 8'h14; 8'h9c: sbout = 8'hde; 8'h9d: sbout = 8'h5e; 8'h9e: sbout = 8'h0b; 8'h9f: sbout = 8'hdb;
            8'ha0: sbout = 8'he0; 8'ha1: sbout = 8'h32; 8'ha2: sbout = 8'h3a; 8'ha3: sbout = 8'h0a; 8'ha4: sbout = 8'h49; 8'ha5: sbout = 8'h06; 8'ha6: sbout = 8'h24; 8'ha7: sbout = 8'h5c; 8'ha8: sbout = 8'hc2; 8'ha9: sbout = 8'hd3; 8'haa: sbout = 8'hac; 8'hab: sbout = 8'h62; 8'hac: sbout = 8'h91; 8'had: sbout = 8'h95; 8'hae: sbout = 8'he4; 8'haf: sbout = 8'h79;
            8'hb0: sbout = 8'he7; 8'hb1: sbout = 8'hc8; 8'hb2: sbout = 8'h37; 8'hb3: sbout = 8'h6d; 8'hb4: sbout = 8'h8d; 8'hb5: sbout = 8'hd5; 8'hb6: sbout = 8'h4e; 8'hb7: sbout = 8'ha9; 8'hb8: sbout = 8'h6c; 8'hb9: sbout = 8'h56; 8'hba: sbout = 8'hf4; 8'hbb: sbout = 8'hea; 8'hbc: sbout = 8'h65; 8'hbd: sbout = 8'h7a; 8'hbe: sbout = 8'hae; 8'hbf: sbout = 8'h08;
            8'hc0: sbout = 8'hba; 8'hc1: sbout = 8'h78; 8'hc2: sbout = 8'h25; 8'hc3: sbout = 8'h2e; 8'hc4: sbout = 8'h1c; 8'hc5: sbout = 8'ha6; 8'hc6: sbout = 8'hb4; 8'hc7: sbout = 8'hc6; 8'hc8: sbout = 8'he8; 8'hc9: sbout = 8'hdd; 8'hca: sbout = 8'h74; 8'hcb: sbout = 8'h1f; 8'hcc: sbout = 8'h4b; 8'hcd: sbout = 8'hbd; 8'hce: sbout = 8'h8b; 8'hcf: sbout = 8'h8a;
            8'hd0: sbout = 8'h70; 8'hd1: sbout = 8'h3e; 8'hd2: sbout = 8'hb5; 8'hd3: sbout = 8'h66; 8'hd4: sbout = 8'h48; 8'hd5: sbout = 8'h03; 8'hd6: sbout = 8'hf6; 8'hd7: sbout = 8'h0e; 8'hd8: sbout = 8'h61; 8'hd9: sbout = 8'h35; 8'hda: sbout = 8'h57; 8'hdb: sbout = 8'hb9; 8'hdc: sbout = 8'h86; 8'hdd: sbout = 8'hc1; 8'hde: sbout = 8'h1d; 8'hdf: sbout = 8'h9e;
            8'he0: sbout = 8'he1; 8'he1: sbout = 8'hf8; 8'he2: sbout = 8'h98; 8'he3: sbout = 8'h11; 8'he4: sbout = 8'h69; 8'he5: sbout = 8'hd9; 8'he6: sbout = 8'h8e; 8'he7: sbout = 8'h94; 8'he8: sbout = 8'h9b; 8'he9: sbout = 8'h1e; 8'hea: sbout = 8'h87; 8'heb: sbout = 8'he9; 8'hec: sbout = 8'hce; 8'hed: sbout = 8'h55; 8'hee: sbout = 8'h28; 8'hef: sbout = 8'hdf;
            8'hf0: sbout = 8'h8c; 8'hf1: sbout = 8'ha1; 8'hf2: sbout = 8'h89; 8'hf3: sbout = 8'h0d; 8'hf4: sbout = 8'hbf; 8'hf5: sbout = 8'he6; 8'hf6: sbout = 8'h42; 8'hf7: sbout = 8'h68; 8'hf8: sbout = 8'h41; 8'hf9: sbout = 8'h99; 8'hfa: sbout = 8'h2d; 8'hfb: sbout = 8'h0f; 8'hfc: sbout = 8'hb0; 8'hfd: sbout = 8'h54; 8'hfe: sbout = 8'hbb; 8'hff: sbout = 8'h16;
            default: sbout = 8'h00;
        endcase
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Forward AES SubBytes over a 128-bit state, LANES bytes per cycle through LANES S-box copies.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:AES_BLOCK_W-1] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:AES_BLOCK_W-1] out_data,
    output logic                   busy
);

    localparam int NSTEP = AES_NBYTES / LANES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sb_state_e               r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic [0:AES_BLOCK_W-1]  r_data;
    logic [0:AES_BYTE_W-1]   w_lane_in  [LANES];
    logic [0:AES_BYTE_W-1]   w_lane_out [LANES];
    logic [AES_NBYTES-1:0]   w_byte_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SB_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            SB_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SB_RUN;
            end
            SB_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_next = SB_DONE;
            end
            SB_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = SB_IDLE;
            end
            default: w_next = SB_IDLE;
        endcase
    end

    // Lane l always serves byte cnt*LANES+l; byte b is written back on the step b/LANES.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_lane_in[l] = r_data[(int'(r_cnt) * LANES + l) * AES_BYTE_W +: AES_BYTE_W];
            sbox u_sbox (
                .sbin  (w_lane_in[l]),
                .sbout (w_lane_out[l])
            );
        end
        for (genvar b = 0; b < AES_NBYTES; b++) begin : g_en
            assign w_byte_en[b] = (r_state == SB_RUN) && (r_cnt == CW'(b / LANES));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else if (in_valid && in_ready) begin
            r_cnt  <= '0;
            r_data <= in_data;
        end else if (r_state == SB_RUN) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            for (int b = 0; b < AES_NBYTES; b++) begin
                if (w_byte_en[b]) r_data[b * AES_BYTE_W +: AES_BYTE_W] <= w_lane_out[b % LANES];
            end
        end
    end

    assign out_data = r_data;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: three instances (LANES=1,4,16) on one clock and reset.
module tb_sub_bytes_engine;

    localparam logic [0:127] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [0:127] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [0:127] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         iv  [3];
    logic         orr [3];
    logic [0:127] id  [3];
    wire          ir  [3];
    wire          ov  [3];
    wire          bz  [3];
    wire  [0:127] od  [3];

    int checks = 0;
    int passes = 0;

    sub_bytes_engine #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .busy(bz[0]));
    sub_bytes_engine #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .busy(bz[1]));
    sub_bytes_engine #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .busy(bz[2]));

    function automatic int nstep(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int lanes(input int d);
        return 16 / nstep(d);
    endfunction

    // Independent S-box model built from GF(2^8) inversion and the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox_ref(input logic [7:0] s);
        return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction. Latency counts the accept edge as edge 1, so out_valid is due at edge NSTEP+1.
    task automatic process_block(input int d, input logic [0:127] blk, input logic [0:127] exp,
                                 input string nm, output logic [0:127] got);
        int n = 0;
        int e;
        got    = '0;
        iv[d]  = 1'b1;
        id[d]  = blk;
        orr[d] = 1'b0;
        while (ir[d] !== 1'b1 && n < 50) begin tick; n++; end
        checks++;
        if (ir[d] !== 1'b1) begin
            $display("FAIL %s L%0d in_ready timeout: in_ready=%b required 1", nm, lanes(d), ir[d]);
            iv[d] = 1'b0;
            return;
        end else passes++;
        tick;
        iv[d] = 1'b0;
        e = 1;
        while (ov[d] !== 1'b1 && e < 100) begin tick; e++; end
        checks++;
        if (e !== nstep(d) + 1)
            $display("FAIL %s L%0d latency: %0d edges required %0d", nm, lanes(d), e, nstep(d) + 1);
        else passes++;
        checks++;
        if (od[d] !== exp) $display("FAIL %s L%0d out_data: %h required %h", nm, lanes(d), od[d], exp);
        else passes++;
        checks++;
        if (ir[d] !== 1'b0 || bz[d] !== 1'b1)
            $display("FAIL %s L%0d done status: in_ready=%b busy=%b required 0 1", nm, lanes(d), ir[d], bz[d]);
        else passes++;
        got    = od[d];
        orr[d] = 1'b1;
        tick;
        orr[d] = 1'b0;
        checks++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1 || bz[d] !== 1'b0)
            $display("FAIL %s L%0d release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     nm, lanes(d), ov[d], ir[d], bz[d]);
        else passes++;
    endtask

    task automatic test_reset;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || od[d] !== 128'h0)
                $display("FAIL reset L%0d: in_ready=%b out_valid=%b busy=%b out_data=%h required 1 0 0 0",
                         lanes(d), ir[d], ov[d], bz[d], od[d]);
            else passes++;
        end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fips;
        logic [0:127] got;
        process_block(1, FIPS_IN, FIPS_OUT, "fips_round1", got);
    endtask

    task automatic test_vectors;
        logic [0:127] got;
        for (int d = 0; d < 3; d++) begin
            process_block(d, 128'h0, {16{8'h63}}, "all_zero", got);
            process_block(d, SEQ_IN, SEQ_OUT, "seq_00_0f", got);
        end
        process_block(2, FIPS_IN, FIPS_OUT, "fips_round1", got);
    endtask

    task automatic test_exhaustive;
        logic [0:127] blk, exp, got, back;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                blk[8*i +: 8] = 8'(16 * k + i);
                exp[8*i +: 8] = sbox_ref(8'(16 * k + i));
            end
            process_block(1, blk, exp, "exhaustive", got);
            for (int i = 0; i < 16; i++) back[8*i +: 8] = inv_sbox_ref(got[8*i +: 8]);
            checks++;
            if (back !== blk) $display("FAIL inverse blk%0d: %h required %h", k, back, blk);
            else passes++;
            if (k == 5) begin
                checks++;
                if (got[24 +: 8] !== 8'hed) $display("FAIL s53: %h required ed", got[24 +: 8]);
                else passes++;
            end
            if (k == 15) begin
                checks++;
                if (got[120 +: 8] !== 8'h16) $display("FAIL sff: %h required 16", got[120 +: 8]);
                else passes++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [0:127] got;
        int n = 0;
        iv[1] = 1'b1; id[1] = FIPS_IN; orr[1] = 1'b0;
        tick;
        iv[1] = 1'b0;
        while (ov[1] !== 1'b1 && n < 50) begin tick; n++; end
        id[1] = {16{8'h53}};
        iv[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== FIPS_OUT || ir[1] !== 1'b0)
                $display("FAIL bp_hold c%0d: out_valid=%b in_ready=%b out_data=%h required 1 0 %h",
                         c, ov[1], ir[1], od[1], FIPS_OUT);
            else passes++;
        end
        orr[1] = 1'b1;
        tick;
        orr[1] = 1'b0;
        checks++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1)
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", ov[1], ir[1]);
        else passes++;
        process_block(1, {16{8'h53}}, {16{8'hed}}, "bp_next", got);
    endtask

    task automatic test_reset_mid;
        logic [0:127] got;
        iv[1] = 1'b1; id[1] = FIPS_IN; orr[1] = 1'b0;
        tick;
        iv[1] = 1'b0;
        tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0 || bz[1] !== 1'b0 || od[1] !== 128'h0)
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b out_data=%h required 1 0 0 0",
                     ir[1], ov[1], bz[1], od[1]);
        else passes++;
        #1 rst_n = 1'b1;
        tick;
        process_block(1, SEQ_IN, SEQ_OUT, "after_reset", got);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bin  [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        logic [7:0] bout [8] = '{8'h63, 8'h82, 8'h93, 8'hc3, 8'h1b, 8'hfc, 8'h33, 8'hf5};
        int sent = 0, recv = 0, cyc = 0, last = -1;
        bit acc;
        orr[1] = 1'b1;
        while (recv < 8 && cyc < 400) begin
            if (ov[1] === 1'b1) begin
                checks++;
                if (od[1] !== {16{bout[recv]}})
                    $display("FAIL b2b blk%0d: %h required %h", recv, od[1], {16{bout[recv]}});
                else passes++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== nstep(1) + 2)
                        $display("FAIL b2b spacing blk%0d: %0d cycles required %0d", recv, cyc - last, nstep(1) + 2);
                    else passes++;
                end
                last = cyc;
                recv++;
            end
            iv[1] = (sent < 8);
            if (sent < 8) id[1] = {16{bin[sent]}};
            acc = (ir[1] === 1'b1) && (sent < 8);
            tick;
            cyc++;
            if (acc) sent++;
        end
        iv[1] = 1'b0;
        orr[1] = 1'b0;
        checks++;
        if (recv !== 8) $display("FAIL b2b count: %0d blocks required 8", recv);
        else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; orr[d] = 1'b0; id[d] = '0;
        end
        test_reset;
        test_fips;
        test_vectors;
        test_exhaustive;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
